// File: rtl/sb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sb_rr_arbiter
//
// Round-robin arbiter merging N switchboard-style streams (data/dest/last/
// valid/ready) into a single output stream. The output is a one-entry
// registered stage that sustains one beat per cycle with out_ready held high.
//
// Optional feature (compile-time macro SB_ARB_PKT_LOCK_EN):
//   defined   - packet locking: a granted input keeps the output until the
//               beat carrying its last flag, so packets stay contiguous.
//   undefined - every accepted beat ends the grant; beats from different
//               sources may interleave and out_src tags each one.
//
// Parameters:
//   N   number of input streams (N >= 2)
//   DW  data width in bits
//   SW  width of the source index ($clog2(N))
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   in_data    N*DW  input data, port i at [i*DW +: DW]
//   in_dest    N*32  input destination, port i at [i*32 +: 32]
//   in_last    N     last-beat flag per input port
//   in_valid   N     beat-valid per input port
//   in_ready   N     beat-accept per input port (at most one bit set)
//   out_data   DW    registered beat data
//   out_dest   32    registered destination
//   out_last   1     registered last flag
//   out_src    SW    index of the input that supplied the current beat
//   out_valid  1     output beat valid
//   out_ready  1     downstream accept
// -----------------------------------------------------------------------------
module sb_rr_arbiter #(
  parameter int N  = 4,
  parameter int DW = 256,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*DW-1:0] in_data,
  input  logic [N*32-1:0] in_dest,
  input  logic [N-1:0]    in_last,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [DW-1:0]   out_data,
  output logic [31:0]     out_dest,
  output logic            out_last,
  output logic [SW-1:0]   out_src,
  output logic            out_valid,
  input  logic            out_ready
);

  // First valid port found scanning p, p+1, ... modulo N. The loop runs from
  // the farthest offset down so the nearest hit is the one left standing.
  function automatic logic [SW-1:0] rr_pick(input logic [N-1:0] v,
                                            input logic [SW-1:0] p);
    int idx;
    rr_pick = p;
    for (int k = N - 1; k >= 0; k--) begin
      idx     = (int'(p) + k) % N;
      rr_pick = v[idx[SW-1:0]] ? idx[SW-1:0] : rr_pick;
    end
  endfunction

  logic          slot_free_s;
  logic          sel_ok_s;
  logic          load_s;
  logic          grant_end_s;
  logic [SW-1:0] sel_s;
  logic [SW-1:0] rr_sel_s;
  logic [SW-1:0] ptr_next_s;
  logic [SW-1:0] ptr_r;

  assign slot_free_s = !out_valid || out_ready;
  assign rr_sel_s    = rr_pick(in_valid, ptr_r);
  assign load_s      = slot_free_s && sel_ok_s;

  // Priority moves to the port just after the one whose grant ended.
  assign ptr_next_s  = (sel_s == SW'(N - 1)) ? {SW{1'b0}} : (sel_s + SW'(1));

`ifdef SB_ARB_PKT_LOCK_EN
  logic          locked_r;
  logic [SW-1:0] lock_port_r;

  // Port selection: a locked packet owns the output even while it idles.
  always_comb begin
    sel_s    = rr_sel_s;
    sel_ok_s = |in_valid;
    if (locked_r) begin
      sel_s    = lock_port_r;
      sel_ok_s = in_valid[lock_port_r];
    end else begin
      sel_s    = rr_sel_s;
      sel_ok_s = |in_valid;
    end
  end

  assign grant_end_s = load_s && in_last[sel_s];

  // Lock state: engaged by a non-last beat, released by the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_r    <= 1'b0;
      lock_port_r <= {SW{1'b0}};
    end else if (load_s) begin
      if (in_last[sel_s]) begin
        locked_r <= 1'b0;
      end else begin
        locked_r    <= 1'b1;
        lock_port_r <= sel_s;
      end
    end
  end
`else
  // Port selection: pure round-robin, every beat re-arbitrated.
  always_comb begin
    sel_s    = rr_sel_s;
    sel_ok_s = |in_valid;
  end

  assign grant_end_s = load_s;
`endif

  // Accept strobe: only the selected port, only when the output slot frees.
  // Held low during reset so no source believes a beat was taken.
  always_comb begin
    in_ready = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      in_ready[i] = !rst && load_s && (sel_s == SW'(i));
    end
  end

  // Round-robin priority pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= {SW{1'b0}};
    end else if (grant_end_s) begin
      ptr_r <= ptr_next_s;
    end
  end

  // Output stage: load the selected beat, drain to empty, or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= {DW{1'b0}};
      out_dest  <= 32'h0000_0000;
      out_last  <= 1'b0;
      out_src   <= {SW{1'b0}};
    end else if (load_s) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(sel_s)*DW +: DW];
      out_dest  <= in_dest[int'(sel_s)*32 +: 32];
      out_last  <= in_last[sel_s];
      out_src   <= sel_s;
    end else if (slot_free_s) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sb_rr_arbiter
//
// Directed bench for sb_rr_arbiter (N=4, DW=16). Inputs are driven 1 ns after
// the rising edge; in_ready is checked before the next edge and registered
// outputs 1 ns after it. Expected values are hand-derived constants.
// The lock tests run when SB_ARB_PKT_LOCK_EN is defined, the interleave test
// otherwise.
// -----------------------------------------------------------------------------
module tb_sb_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] in_data;
  logic [N*32-1:0] in_dest;
  logic [N-1:0]    in_last;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [DW-1:0]   out_data;
  logic [31:0]     out_dest;
  logic            out_last;
  logic [SW-1:0]   out_src;
  logic            out_valid;
  logic            out_ready;

  int checks_total  = 0;
  int checks_passed = 0;

  sb_rr_arbiter #(.N(N), .DW(DW), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_dest  (out_dest),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    checks_total++;
    if (obs === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic [DW-1:0] d,
                          input logic l);
    in_valid[p]           = v;
    in_data[p*DW +: DW]   = d;
    in_dest[p*32 +: 32]   = {16'hD000, d};
    in_last[p]            = l;
  endtask

  task automatic check_beat(input string tag, input logic [SW-1:0] src,
                            input logic [DW-1:0] d, input logic l);
    check_val({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_val({tag, "_src"},   64'(out_src),   64'(src));
    check_val({tag, "_data"},  64'(out_data),  64'(d));
    check_val({tag, "_last"},  64'(out_last),  64'(l));
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    in_dest   = '0;
    in_last   = '0;
    for (int p = 0; p < N; p++) set_port(p, 1'b1, 16'(16'h0010 + p), 1'b1);

    // Reset with every input valid.
    tick();
    tick();
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_data",  64'(out_data),  64'd0);
    check_val("rst_out_dest",  64'(out_dest),  64'd0);
    check_val("rst_out_last",  64'(out_last),  64'd0);
    check_val("rst_out_src",   64'(out_src),   64'd0);
    check_val("rst_in_ready",  64'(in_ready),  64'd0);

    // Release: port 0 accepted first, visible the following cycle.
    rst = 1'b0;
    #1;
    check_val("rel_in_ready", 64'(in_ready), 64'b0001);
    tick();
    check_beat("rel_beat", 2'd0, 16'h0010, 1'b1);
    check_val("rel_dest", 64'(out_dest), 64'hD000_0010);

    // Fairness: 0,1,2,3,0,1,2,3 one beat per cycle.
    for (int k = 1; k < 8; k++) begin
      check_val("fair_in_ready", 64'(in_ready), 64'(4'b0001 << (k % 4)));
      tick();
      check_beat("fair", SW'(k % 4), 16'(16'h0010 + (k % 4)), 1'b1);
    end

    // Drain; pointer is back at 0.
    in_valid = '0;
    tick();
    check_val("drain1_valid", 64'(out_valid), 64'd0);

    // Back-pressure: 0x55 held for 5 cycles, nothing accepted.
    set_port(0, 1'b1, 16'h0055, 1'b1);
    out_ready = 1'b0;
    #1;
    check_val("bp_first_ready", 64'(in_ready), 64'b0001);
    tick();
    check_beat("bp_load", 2'd0, 16'h0055, 1'b1);
    set_port(0, 1'b1, 16'h0066, 1'b1);
    set_port(1, 1'b1, 16'h0077, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      check_val("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
      check_beat("bp_hold", 2'd0, 16'h0055, 1'b1);
    end
    // Release: next beat (port 1, pointer at 1) loads in the same cycle.
    out_ready = 1'b1;
    #1;
    check_val("bp_rel_ready", 64'(in_ready), 64'b0010);
    tick();
    check_beat("bp_nobubble", 2'd1, 16'h0077, 1'b1);

    // Drain; pointer now at 2.
    in_valid = '0;
    tick();
    check_val("drain2_valid", 64'(out_valid), 64'd0);

`ifdef SB_ARB_PKT_LOCK_EN
    // Lock: 3-beat packet on port 2 while port 0 waits, with an idle gap.
    set_port(2, 1'b1, 16'h00A0, 1'b0);
    set_port(0, 1'b1, 16'h0010, 1'b1);
    #1;
    check_val("lk_rdy0", 64'(in_ready), 64'b0100);
    tick();
    check_beat("lk_a0", 2'd2, 16'h00A0, 1'b0);
    set_port(2, 1'b1, 16'h00A1, 1'b0);
    #1;
    check_val("lk_rdy1", 64'(in_ready), 64'b0100);
    tick();
    check_beat("lk_a1", 2'd2, 16'h00A1, 1'b0);
    in_valid[2] = 1'b0;
    #1;
    check_val("lk_idle_rdy", 64'(in_ready), 64'd0);
    tick();
    check_val("lk_idle_valid", 64'(out_valid), 64'd0);
    set_port(2, 1'b1, 16'h00A2, 1'b1);
    #1;
    check_val("lk_rdy2", 64'(in_ready), 64'b0100);
    tick();
    check_beat("lk_a2", 2'd2, 16'h00A2, 1'b1);
    in_valid[2] = 1'b0;
    #1;
    check_val("lk_after_rdy", 64'(in_ready), 64'b0001);
    tick();
    check_beat("lk_after", 2'd0, 16'h0010, 1'b1);

    // Mid-packet reset on port 3 (pointer at 1).
    in_valid = '0;
    set_port(3, 1'b1, 16'h00C0, 1'b0);
    #1;
    check_val("mr_rdy0", 64'(in_ready), 64'b1000);
    tick();
    check_beat("mr_c0", 2'd3, 16'h00C0, 1'b0);
    set_port(3, 1'b1, 16'h00C1, 1'b0);
    set_port(0, 1'b1, 16'h0010, 1'b1);
    rst = 1'b1;
    #1;
    check_val("mr_async_valid", 64'(out_valid), 64'd0);
    check_val("mr_async_rdy",   64'(in_ready),  64'd0);
    tick();
    rst = 1'b0;
    #1;
    check_val("mr_rel_rdy", 64'(in_ready), 64'b0001);
    tick();
    check_beat("mr_first", 2'd0, 16'h0010, 1'b1);
`else
    // Interleave: two 2-beat packets on ports 0 and 1.
    set_port(0, 1'b1, 16'h00A0, 1'b0);
    set_port(1, 1'b1, 16'h00B0, 1'b0);
    #1;
    check_val("il_rdy0", 64'(in_ready), 64'b0001);
    tick();
    check_beat("il_b0", 2'd0, 16'h00A0, 1'b0);
    set_port(0, 1'b1, 16'h00A1, 1'b1);
    #1;
    check_val("il_rdy1", 64'(in_ready), 64'b0010);
    tick();
    check_beat("il_b1", 2'd1, 16'h00B0, 1'b0);
    set_port(1, 1'b1, 16'h00B1, 1'b1);
    #1;
    check_val("il_rdy2", 64'(in_ready), 64'b0001);
    tick();
    check_beat("il_b2", 2'd0, 16'h00A1, 1'b1);
    in_valid[0] = 1'b0;
    #1;
    check_val("il_rdy3", 64'(in_ready), 64'b0010);
    tick();
    check_beat("il_b3", 2'd1, 16'h00B1, 1'b1);
`endif

    in_valid = '0;
    tick();
    check_val("final_drain", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
